// File: rtl/fw_update_ctrl.sv
// Firmware-update sequencer: hunts a framed image on the UART byte
// stream and writes little-endian words into flash emulator memory.
module fw_update_ctrl #(
  parameter int          ADDR_W  = 16,
  parameter logic [23:0] TIMEOUT = 24'd120000
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              enable_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        err_o,
  output logic [15:0]       words_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_HDR, S_DATA,
    S_WRITE, S_CHK, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       hdr_q, hdr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       rem_q, rem_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        xor_q, xor_d;
  logic [23:0]       idle_q, idle_d;
  logic [15:0]       words_q, words_d;
  logic [2:0]        err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;

  logic        acc;
  logic        cnt_st;
  logic [15:0] h_addr;
  logic [15:0] h_len;
  logic [16:0] h_end;
  logic [16:0] h_lim;
  logic        h_hi;

  // Byte acceptance decodes the state register directly.
  always_comb begin
    rx_ready_o = 1'b0;
    if (rstn_i && enable_i) begin
      rx_ready_o = (state_q == S_IDLE) || (state_q == S_SYNC) ||
                   (state_q == S_HDR)  || (state_q == S_DATA) ||
                   (state_q == S_CHK);
    end
  end

  assign acc    = rx_valid_i & rx_ready_o;
  assign cnt_st = (state_q == S_SYNC) || (state_q == S_HDR) ||
                  (state_q == S_DATA) || (state_q == S_CHK);
  assign h_addr = hdr_q[15:0];
  assign h_len  = {rx_data_i, hdr_q[23:16]};
  assign h_end  = {1'b0, h_addr} + {1'b0, h_len};
  assign h_lim  = 17'd1 << ADDR_W;
  assign h_hi   = (32'(h_addr) >> ADDR_W) != 32'd0;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    xor_d   = xor_q;
    idle_d  = idle_q;
    words_d = words_q;
    err_d   = err_q;
    done_d  = done_q;
    if (!enable_i) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      err_d   = 3'd0;
      words_d = 16'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (acc && rx_data_i == 8'hAA) state_d = S_SYNC;
        end
        S_SYNC: begin
          if (acc) begin
            if (rx_data_i == 8'h55) begin
              state_d = S_HDR;
              xor_d   = 8'd0;
              words_d = 16'd0;
              cnt_d   = 2'd0;
            end else if (rx_data_i != 8'hAA) begin
              state_d = S_IDLE;
            end
          end
        end
        S_HDR: begin
          if (acc) begin
            xor_d = xor_q ^ rx_data_i;
            hdr_d = {rx_data_i, hdr_q[23:8]};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (h_len == 16'd0) begin
                state_d = S_ERR;
                err_d   = 3'd1;
              end else if (h_hi || h_end > h_lim) begin
                state_d = S_ERR;
                err_d   = 3'd2;
              end else begin
                state_d = S_DATA;
                addr_d  = h_addr[ADDR_W-1:0];
                rem_d   = h_len;
              end
            end
          end
        end
        S_DATA: begin
          if (acc) begin
            xor_d  = xor_q ^ rx_data_i;
            word_d = {rx_data_i, word_q[31:8]};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_gnt_i) begin
            addr_d  = addr_q + ADDR_W'(1);
            rem_d   = rem_q - 16'd1;
            words_d = words_q + 16'd1;
            state_d = (rem_q == 16'd1) ? S_CHK : S_DATA;
          end
        end
        S_CHK: begin
          if (acc) begin
            if (rx_data_i == xor_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ERR;
              err_d   = 3'd3;
            end
          end
        end
        S_DONE: ;
        S_ERR: ;
      endcase
      if (cnt_st && !acc && idle_q == TIMEOUT - 24'd1) begin
        state_d = S_ERR;
        err_d   = 3'd4;
      end
    end
    if (state_d != state_q || acc) idle_d = 24'd0;
    else if (cnt_st) idle_d = idle_q + 24'd1;
    req_d  = (state_d == S_WRITE);
    busy_d = (state_d == S_SYNC) || (state_d == S_HDR) ||
             (state_d == S_DATA) || (state_d == S_WRITE) ||
             (state_d == S_CHK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      hdr_q   <= 24'd0;
      addr_q  <= '0;
      rem_q   <= 16'd0;
      word_q  <= 32'd0;
      xor_q   <= 8'd0;
      idle_q  <= 24'd0;
      words_q <= 16'd0;
      err_q   <= 3'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      xor_q   <= xor_d;
      idle_q  <= idle_d;
      words_q <= words_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = word_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign words_o     = words_q;

endmodule

// File: tb/tb_fw_update_ctrl.sv
// Randomised frame-level bench for fw_update_ctrl with a
// frame-parsing reference model and a write scoreboard.
module tb_fw_update_ctrl;
  localparam int AW = 16;
  localparam logic [23:0] TO = 24'd50;

  logic clk = 1'b0, rstn = 1'b0, en = 1'b0;
  logic rxv = 1'b0, gnt = 1'b0;
  logic [7:0] rxd = 8'd0;
  logic rxr, req, we, busy, done;
  logic [AW-1:0] maddr;
  logic [31:0] wd;
  logic [2:0] err;
  logic [15:0] words;

  int checks = 0, errors = 0;
  int gmode = 0, wait_cnt = 0, req_cyc = 0;
  logic prev_req = 1'b0, prev_gnt = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [31:0] pdata = 32'd0;
  logic [47:0] got[$];
  logic [47:0] expw[$];
  logic [7:0] fr[$];
  int nsend, e_words;
  logic [2:0] e_err;
  logic e_done;

  fw_update_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(en),
    .rx_valid_i(rxv), .rx_data_i(rxd), .rx_ready_o(rxr),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(maddr),
    .mem_wdata_o(wd), .mem_gnt_i(gnt), .busy_o(busy),
    .done_o(done), .err_o(err), .words_o(words)
  );

  always #5 clk = ~clk;

  // Grant driver and write monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    logic g;
    case (gmode)
      0: g = 1'b1;
      1: g = req && wait_cnt == 5;
      2: g = req && ($urandom_range(0, 2) == 0);
      default: g = 1'b0;
    endcase
    if (req) begin
      req_cyc++;
      checks++;
      if (we !== 1'b1 || rxr !== 1'b0) begin
        errors++;
        $display("FAIL write_ctl we=%b rx_ready=%b need we=1 rx_ready=0",
                 we, rxr);
      end
      if (prev_req && !prev_gnt) begin
        checks++;
        if (maddr !== paddr || wd !== pdata) begin
          errors++;
          $display("FAIL req_stable addr=%h data=%h need %h %h",
                   maddr, wd, paddr, pdata);
        end
      end
      wait_cnt++;
    end
    if (req && g) begin
      got.push_back({maddr, wd});
      wait_cnt = 0;
    end
    gnt = g;
    prev_req = req;
    prev_gnt = g;
    paddr = maddr;
    pdata = wd;
  end

  // Reference: parse one frame from its first AA by the frame rules.
  task automatic model();
    int a, l, x, lim;
    logic [31:0] d;
    a = int'({fr[3], fr[2]});
    l = int'({fr[5], fr[4]});
    lim = 1 << AW;
    expw.delete();
    e_err = 3'd0;
    e_done = 1'b0;
    e_words = 0;
    nsend = 6;
    if (l == 0) e_err = 3'd1;
    else if (a + l > lim) e_err = 3'd2;
    else begin
      x = 0;
      for (int i = 2; i < 6; i++) x = x ^ int'(fr[i]);
      for (int w = 0; w < l; w++) begin
        d = 32'd0;
        for (int b = 0; b < 4; b++) begin
          d = d | (32'(fr[6 + 4 * w + b]) << (8 * b));
          x = x ^ int'(fr[6 + 4 * w + b]);
        end
        expw.push_back({16'(a + w), d});
      end
      e_words = l;
      nsend = 7 + 4 * l;
      if (int'(fr[6 + 4 * l]) == x) e_done = 1'b1;
      else e_err = 3'd3;
    end
  endtask

  task automatic make_frame(input int a, input int l, input bit bad);
    logic [7:0] x, b;
    fr.delete();
    fr.push_back(8'hAA);
    fr.push_back(8'h55);
    fr.push_back(a[7:0]);
    fr.push_back(a[15:8]);
    fr.push_back(l[7:0]);
    fr.push_back(l[15:8]);
    x = a[7:0] ^ a[15:8] ^ l[7:0] ^ l[15:8];
    for (int i = 0; i < 4 * l; i++) begin
      b = 8'($urandom);
      fr.push_back(b);
      x = x ^ b;
    end
    fr.push_back(bad ? ~x : x);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    rxv = 1'b1;
    rxd = b;
    while (!rxr && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_wait byte=%h never accepted", b);
    end
    @(negedge clk);
    rxv = 1'b0;
  endtask

  task automatic restart();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    got.delete();
    req_cyc = 0;
  endtask

  task automatic check_status(input string nm);
    checks++;
    if (err !== e_err || done !== e_done || words !== 16'(e_words)) begin
      errors++;
      $display("FAIL %s_status err=%0d done=%b words=%0d need %0d %b %0d",
               nm, err, done, words, e_err, e_done, e_words);
    end
    checks++;
    if (got.size() != expw.size()) begin
      errors++;
      $display("FAIL %s_nwrites got=%0d need %0d",
               nm, got.size(), expw.size());
    end else begin
      foreach (expw[i]) begin
        checks++;
        if (got[i] !== expw[i]) begin
          errors++;
          $display("FAIL %s_write%0d got=%h need %h",
                   nm, i, got[i], expw[i]);
        end
      end
    end
    if (e_err == 3'd1 || e_err == 3'd2) begin
      checks++;
      if (req_cyc != 0) begin
        errors++;
        $display("FAIL %s_noreq req_cycles=%0d need 0", nm, req_cyc);
      end
    end
  endtask

  task automatic run_frame(input string nm, input int maxgap);
    restart();
    model();
    for (int i = 0; i < nsend; i++) send_byte(fr[i], $urandom_range(0, maxgap));
    check_status(nm);
  endtask

  task automatic check_idle_outs(input string nm);
    checks++;
    if (rxr !== 1'b0 || req !== 1'b0 || we !== 1'b0 || maddr !== '0 ||
        wd !== 32'd0 || busy !== 1'b0 || done !== 1'b0 ||
        err !== 3'd0 || words !== 16'd0) begin
      errors++;
      $display("FAIL %s rdy=%b req=%b we=%b a=%h d=%h b=%b dn=%b e=%0d w=%0d need all 0",
               nm, rxr, req, we, maddr, wd, busy, done, err, words);
    end
  endtask

  task automatic test_reset();
    en = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outs("reset");
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    gmode = 0;
    fr = '{8'hAA, 8'h55, 8'h10, 8'h00, 8'h01, 8'h00,
           8'h78, 8'h56, 8'h34, 8'h12, 8'h19};
    run_frame("basic", 2);
    checks++;
    if (got.size() != 1 || got[0] !== {16'h0010, 32'h12345678} ||
        done !== 1'b1 || err !== 3'd0 || words !== 16'd1) begin
      errors++;
      $display("FAIL basic_fixed n=%0d w=%h dn=%b e=%0d need 1 0010_12345678 1 0",
               got.size(), got.size() > 0 ? got[0] : 48'h0, done, err);
    end
  endtask

  task automatic test_bad_chk();
    gmode = 0;
    fr = '{8'hAA, 8'h55, 8'h10, 8'h00, 8'h01, 8'h00,
           8'h78, 8'h56, 8'h34, 8'h12, 8'h18};
    run_frame("badchk", 2);
  endtask

  task automatic test_zero_len();
    gmode = 0;
    make_frame(16'h0100, 0, 1'b0);
    run_frame("zerolen", 1);
  endtask

  task automatic test_range();
    gmode = 0;
    make_frame(16'hFFFF, 2, 1'b0);
    run_frame("range", 1);
    make_frame(16'hFFFE, 2, 1'b0);
    run_frame("range_edge", 1);
  endtask

  task automatic test_gnt_wait();
    gmode = 1;
    make_frame(16'h0200, 3, 1'b0);
    run_frame("gntwait", 0);
    gmode = 0;
  endtask

  task automatic test_noise();
    gmode = 0;
    make_frame(16'h0300, 1, 1'b0);
    restart();
    model();
    send_byte(8'h12, 0);
    send_byte(8'hAA, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL noise_sync busy=%b need 1", busy);
    end
    for (int i = 0; i < nsend; i++) send_byte(fr[i], $urandom_range(0, 2));
    check_status("noise");
  endtask

  task automatic test_timeout();
    gmode = 0;
    make_frame(16'h0040, 2, 1'b0);
    restart();
    for (int i = 0; i < 8; i++) send_byte(fr[i], $urandom_range(0, 3));
    repeat (49) @(negedge clk);
    checks++;
    if (err !== 3'd0) begin
      errors++;
      $display("FAIL timeout_early err=%0d need 0", err);
    end
    @(negedge clk);
    checks++;
    if (err !== 3'd4 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout err=%0d busy=%b done=%b need 4 0 0",
               err, busy, done);
    end
  endtask

  task automatic test_enable_drop();
    gmode = 3;
    make_frame(16'h0020, 1, 1'b0);
    restart();
    for (int i = 0; i < 10; i++) send_byte(fr[i], 0);
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("FAIL drop_pending req=%b need 1", req);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        err !== 3'd0 || words !== 16'd0 || rxr !== 1'b0) begin
      errors++;
      $display("FAIL drop req=%b busy=%b done=%b err=%0d words=%0d rdy=%b need all 0",
               req, busy, done, err, words, rxr);
    end
    en = 1'b1;
    #1;
    checks++;
    if (rxr !== 1'b1) begin
      errors++;
      $display("FAIL drop_idle rx_ready=%b need 1", rxr);
    end
    gmode = 0;
  endtask

  task automatic test_reset_mid();
    gmode = 0;
    make_frame(16'h0050, 2, 1'b0);
    restart();
    for (int i = 0; i < 8; i++) send_byte(fr[i], 0);
    rstn = 1'b0;
    @(negedge clk);
    check_idle_outs("reset_mid");
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    gmode = 2;
    for (int k = 0; k < 8; k++) begin
      int a, l;
      a = (k == 7) ? 16'hFFFD : int'($urandom_range(0, 65535));
      l = (k == 7) ? 3 : int'($urandom_range(0, 4));
      make_frame(a, l, $urandom_range(0, 3) == 0);
      run_frame("random", 3);
    end
    gmode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_chk();
    test_zero_len();
    test_range();
    test_gnt_wait();
    test_noise();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fw_update_ctrl.md
# fw_update_ctrl

Firmware-update sequencer between the UART receive byte stream and the flash emulator write port. When armed by software (via GPIO), it hunts for a framed image, assembles little-endian 32-bit words and writes them into flash emulator memory through a req/gnt handshake. It checks the frame and reports done or error status, which the boot ROM polls before jumping to the new image.

## Interface
- ADDR_W, 16, flash word-address width (1..16)
- TIMEOUT, 24'd120000, max idle cycles between accepted bytes while a frame is in progress (>0)
- clk_i  in  1  clock
- rstn_i  in  1  reset, synchronous, active-low
- enable_i  in  1  arm update mode; low aborts and clears status
- rx_valid_i  in  1  received byte valid
- rx_data_i  in  8  received byte
- rx_ready_o  out  1  byte accepted when rx_valid_i & rx_ready_o
- mem_req_o  out  1  flash write request
- mem_we_o  out  1  write enable (equals mem_req_o)
- mem_addr_o  out  ADDR_W  word address
- mem_wdata_o  out  32  write data
- mem_gnt_i  in  1  write grant; completes request in same cycle
- busy_o  out  1  frame in progress
- done_o  out  1  frame written and checksum good
- err_o  out  3  0 none, 1 zero length, 2 range, 3 checksum, 4 timeout
- words_o  out  16  words written in current/last frame

## Operation
- Frame: 0xAA, 0x55, ADDR lo, ADDR hi, LEN lo, LEN hi (words), LEN×4 payload bytes (word LSB first), CHK. CHK is the XOR of all bytes from ADDR lo through the last payload byte.
- States: IDLE, SYNC, HDR, DATA, WRITE, CHK, DONE, ERR.
- rx_ready_o is 1 only when enable_i=1 and the state is IDLE, SYNC, HDR, DATA or CHK.
- IDLE: on an accepted 0xAA go to SYNC; other bytes are discarded.
- SYNC: on 0x55 go to HDR, clear the XOR accumulator and words_o. On 0xAA stay in SYNC. Any other byte returns to IDLE.
- HDR: accept 4 bytes. After the 4th byte:
  - LEN==0 -> ERR, err 1.
  - ADDR+LEN > 2^ADDR_W (17-bit compare) -> ERR, err 2. ADDR bits above ADDR_W must be zero or this also gives err 2.
  - Otherwise go to DATA with remaining=LEN.
- DATA: accept 4 bytes into the word; after the 4th byte go to WRITE.
- WRITE: mem_req_o=1, with addr/wdata held stable until mem_gnt_i. On grant: addr+1, remaining-1, words_o+1. If remaining was 1 go to CHK, else go to DATA.
- CHK: accept 1 byte. If it equals the XOR accumulator go to DONE, else go to ERR with err 3.
- DONE/ERR: hold status until enable_i goes low.
- Payload is written as it streams. A checksum error does not roll back writes; software must treat the image as invalid.
- Timeout: an idle counter runs in SYNC, HDR, DATA and CHK. It resets on each accepted byte and on state entry, and is frozen in WRITE. When it reaches TIMEOUT -> ERR, err 4.
- enable_i=0 in any state: next state is IDLE, mem_req_o drops, and done_o, err_o and words_o clear. If a grant arrives in the same cycle as enable_i=0, that write counts as done in memory but is not reported.

## Timing
- All outputs are registered except rx_ready_o, which decodes the state register and enable_i.
- Reset values: rx_ready_o=0 while rstn_i=0; mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, err_o=0, words_o=0; state IDLE.
- At most one byte is accepted per cycle. A state change takes effect the cycle after the accepting edge.
- mem_req_o rises the cycle after the 4th payload byte is accepted. With mem_gnt_i tied high, each word costs 4 accept cycles plus 1 WRITE cycle.
- The request stays asserted, with stable addr/wdata, for any number of gnt-low cycles. It deasserts the cycle after grant.
- busy_o=1 in SYNC through CHK. done_o/err_o assert the cycle after the deciding byte or timeout.
- Reset mid-frame returns the block to IDLE on the next edge with rstn_i=0, with no partial request left pending.

## Test plan
- Frame AA 55 10 00 01 00 78 56 34 12 19, gnt tied high -> one write, addr 0x0010, data 0x12345678; then done_o=1, err_o=0, words_o=1.
- Same frame with CHK=0x18 -> write still occurs; err_o=3, done_o=0.
- Header LEN=0 -> err_o=1, no mem_req_o. With ADDR_W=16, ADDR=0xFFFF and LEN=2 -> err_o=2, no write.
- 3-word frame with gnt delayed 5 cycles on each request -> mem_addr_o/mem_wdata_o stable during the wait, rx_ready_o=0 in WRITE, addresses sequential, words_o=3, done_o=1.
- Noise 12 AA AA 55 followed by a valid header -> locks after the second AA. With TIMEOUT=50 and the stream stopped mid-payload -> err_o=4 exactly 50 cycles after the last accepted byte.
- enable_i dropped while a request is pending -> mem_req_o=0 the next cycle, state IDLE, status cleared. rstn_i=0 mid-DATA -> all outputs at reset values.
